serial_word_framer: RTL and testbench
=====================================

# serial_word_framer

Upstream feeder for the bit-serial two's-complement stage. Accepts parallel WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts each word out LSB-first, one bit per clock. Before every word it issues a one-cycle `frame_clr` pulse. That pulse drives the complementer's reset, so each word is complemented independently.

## Interface
- `WIDTH`, default 8: word length in bits; legal range ≥ 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high.
- `in_data`  input  WIDTH  parallel word; bit 0 is sent first.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_ready`  output  1  holding register empty; word accepted on an edge where `in_valid & in_ready`.
- `ser_out`  output  1  serial data bit, to the complementer's `in`.
- `ser_valid`  output  1  `ser_out` carries a data bit this cycle.
- `ser_last`  output  1  current bit is bit WIDTH-1 of the word.
- `frame_clr`  output  1  one-cycle pulse before each word, to the complementer's `reset`.
- `busy`  output  1  FSM not in IDLE, or holding register full.

## Operation
- **Storage**
  - Holding register `hold` plus flag `hold_full`.
  - Shift register `sh`.
  - Bit counter `cnt`, width ceil(log2(WIDTH)).
- **Input**
  - `in_ready = ~hold_full`, decoded directly from the flag.
  - On an accept edge: `hold <= in_data`, `hold_full <= 1`.
  - While `hold_full = 1`, `in_data` and `in_valid` are ignored.
- **FSM states:** IDLE, CLEAR, SHIFT.
  - IDLE: if `hold_full` → CLEAR; `sh <= hold`; `hold_full <= 0`.
  - CLEAR: `frame_clr = 1`, `ser_valid = 0`, `ser_out = 0`; `cnt <= 0`; → SHIFT.
  - SHIFT: `ser_out = sh[0]`, `ser_valid = 1`, `ser_last = (cnt == WIDTH-1)`.
    - Each edge: `sh <= sh >> 1`, `cnt <= cnt + 1`.
    - When `cnt == WIDTH-1`:
      - if `hold_full` → CLEAR, and `sh`/`hold_full` reload as in IDLE;
      - else → IDLE.
- **Output decoding**
  - All serial outputs are decoded from registered state: `sh[0]`, the FSM state, and `cnt`. No combinational path runs from `in_*` to `ser_*`/`frame_clr`.
  - `in_ready` does depend on `hold_full` only, which is a register.
- **Arithmetic:** `cnt` never wraps past WIDTH-1; it is reloaded in CLEAR.
- **Simultaneous reload and accept.** On the edge where the shifter reloads from `hold` (leaving IDLE or the last SHIFT bit), `in_ready` was 0, so no accept can coincide. `hold_full` simply clears, and `in_ready` rises the next cycle.
- **Accept in SHIFT.** An accept during SHIFT with the hold empty is legal. The word waits in `hold` until the current word's last bit.
- **Reset (asynchronous, any state, including mid-word)**
  - FSM → IDLE; `hold_full`, `cnt`, `sh` → 0.
  - Any partial word and any buffered word are discarded.
  - Outputs after reset: `ser_out = 0`, `ser_valid = 0`, `ser_last = 0`, `frame_clr = 0`, `busy = 0`, `in_ready = 1`.

## Timing
- **Accept at edge k, FSM in IDLE:**
  - edge k+1 → CLEAR, so `frame_clr = 1` during cycle k+1;
  - bit 0 during cycle k+2;
  - bit WIDTH-1 during cycle k+WIDTH+1.
- **Complementer latency.** The downstream stage registers its output, so the complemented bit i appears one cycle after bit i is presented.
- **Back-to-back words.** Frame period is WIDTH+1 cycles: WIDTH data cycles plus one CLEAR gap. No idle cycle is inserted when `hold` is already full at `ser_last`.
- **Clear/data separation.** `frame_clr` and `ser_valid` are never high in the same cycle. `frame_clr` is high for exactly one cycle per word.
- **Minimum acceptance rate.** After the reload edge, `in_ready` returns to 1 on the next cycle. One new word can therefore be accepted per frame.

## Test plan
- **Single word, WIDTH=8.**
  - Stimulus: after reset, accept `in_data = 8'h06`.
  - Required: `frame_clr` high for 1 cycle; then `ser_out` = 0,1,1,0,0,0,0,0 with `ser_valid = 1` for 8 cycles; `ser_last` only on the 8th; then IDLE with `busy = 0`.
  - With the complementer attached, its output bits assemble to 8'hFA.
- **Back-to-back.**
  - Stimulus: `in_valid` held high with words 8'h01, 8'h80, 8'hFF.
  - Required: three frames of 9 cycles each with no gap beyond CLEAR; `in_ready` drops while `hold` is full.
  - Complementer output: 8'hFF, 8'h80, 8'h01.
- **Backpressure.**
  - Stimulus: present 8'h55, then 8'hAA, then 8'h33 while the first word is shifting.
  - Required: 8'hAA is buffered and 8'h33 is not accepted (`in_ready = 0`) until `hold` drains; order is preserved; no word is lost or duplicated.
- **Reset mid-word.**
  - Stimulus: assert `reset` at bit 3 of 8'h0F with a second word buffered.
  - Required: outputs go to their reset values immediately; after release, nothing is emitted until a new accept; `in_ready = 1`.
- **WIDTH=2 boundary.**
  - Stimulus: words 2'b10 then 2'b01 back-to-back.
  - Required: frames are CLEAR, 0, 1, CLEAR, 1, 0; `ser_last` on the 2nd bit of each frame; counter does not overrun.
- **Zero word.**
  - Stimulus: word 8'h00.
  - Required: eight 0 bits are emitted; complementer output stays 0 throughout the frame.

Source files
------------

// File: rtl/serial_word_framer_if.sv
// Parallel-word input handshake and serial/frame outputs of serial_word_framer.
// master = word producer / serial consumer side, slave = the framer itself.
interface serial_word_framer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             frame_clr;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_last, frame_clr, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_last, frame_clr, busy
  );
endinterface

// File: rtl/serial_word_framer.sv
// Buffers one parallel word and shifts words out LSB-first, preceding each
// word with a one-cycle frame_clr pulse for the downstream complementer.
module serial_word_framer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_word_framer_if.slave bus
);

  localparam int unsigned      CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ser_out_c;
  logic ser_valid_c;
  logic ser_last_c;
  logic frame_clr_c;
  logic accept;

  assign accept = bus.in_valid & ~hold_full_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
    end
  end

  // Accept and reload are mutually exclusive: accept needs hold empty,
  // reload needs hold full, so both may share hold_full_d without priority.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    ser_out_c   = 1'b0;
    ser_valid_c = 1'b0;
    ser_last_c  = 1'b0;
    frame_clr_c = 1'b0;

    if (accept) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = CLEAR;
          sh_d        = hold_q;
          hold_full_d = 1'b0;
        end
      end
      CLEAR: begin
        frame_clr_c = 1'b1;
        cnt_d       = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        ser_out_c   = sh_q[0];
        ser_valid_c = 1'b1;
        ser_last_c  = (cnt_q == LAST);
        sh_d        = sh_q >> 1;
        if (cnt_q == LAST) begin
          if (hold_full_q) begin
            state_d     = CLEAR;
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = ~hold_full_q;
  assign bus.busy      = (state_q != IDLE) | hold_full_q;
  assign bus.ser_out   = ser_out_c;
  assign bus.ser_valid = ser_valid_c;
  assign bus.ser_last  = ser_last_c;
  assign bus.frame_clr = frame_clr_c;

  a_clr_data_excl: assert property (@(posedge clk) disable iff (reset)
    !(frame_clr_c && ser_valid_c));

endmodule

// File: tb/tb_serial_word_framer.sv
// Directed bench for serial_word_framer at WIDTH=8 and WIDTH=2, with a small
// serial two's-complement model standing in for the downstream stage.
module tb_serial_word_framer;

  logic clk;
  logic reset;

  serial_word_framer_if #(.WIDTH(8)) b8 ();
  serial_word_framer_if #(.WIDTH(2)) b2 ();

  serial_word_framer #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(b8));
  serial_word_framer #(.WIDTH(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp = {in_ready, busy, frame_clr, ser_valid, ser_out, ser_last}
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [5:0] exp;
  } row_t;

  row_t t8[$];
  row_t t2[$];

  task automatic add8(input logic v, input logic [7:0] d, input logic [5:0] exp);
    row_t r;
    r.v = v; r.d = d; r.exp = exp;
    t8.push_back(r);
  endtask

  task automatic add2(input logic v, input logic [7:0] d, input logic [5:0] exp);
    row_t r;
    r.v = v; r.d = d; r.exp = exp;
    t2.push_back(r);
  endtask

  // Monitor of the WIDTH=8 stream plus downstream complementer model.
  int         cyc = 0;
  logic [7:0] words8[$];
  logic [7:0] comp8[$];
  int         clr8[$];
  logic [7:0] mon_sr;
  logic [7:0] comp_sr;
  int         comp_bits;
  logic       comp_seen, comp_q, comp_v;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_seen <= 1'b0;
      comp_q    <= 1'b0;
      comp_v    <= 1'b0;
      comp_bits <= 0;
      mon_sr    <= '0;
      comp_sr   <= '0;
    end else begin
      if (b8.frame_clr) begin
        clr8.push_back(cyc);
        comp_seen <= 1'b0;
        comp_q    <= 1'b0;
        comp_v    <= 1'b0;
      end else begin
        comp_v <= b8.ser_valid;
        if (b8.ser_valid) begin
          comp_q    <= b8.ser_out ^ comp_seen;
          comp_seen <= comp_seen | b8.ser_out;
        end
      end
      if (b8.ser_valid) begin
        mon_sr <= {b8.ser_out, mon_sr[7:1]};
        if (b8.ser_last) words8.push_back({b8.ser_out, mon_sr[7:1]});
      end
      if (comp_v) begin
        comp_sr <= {comp_q, comp_sr[7:1]};
        if (comp_bits == 7) begin
          comp8.push_back({comp_q, comp_sr[7:1]});
          comp_bits <= 0;
        end else begin
          comp_bits <= comp_bits + 1;
        end
      end
    end
  end

  task automatic send8(input logic [7:0] w, output int waited);
    b8.in_valid = 1'b1;
    b8.in_data  = w;
    waited      = 0;
    while (!b8.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!b8.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send timeout: word %0h never accepted", w);
    end
    tick();
  endtask

  task automatic check_words(input string name, input logic [7:0] q[$], input logic [7:0] exp[$]);
    check({name, " count"}, q.size(), exp.size());
    foreach (exp[i])
      check($sformatf("%s[%0d]", name, i), (i < q.size()) ? {24'd0, q[i]} : 32'hDEAD, {24'd0, exp[i]});
  endtask

  task automatic clear_mon();
    words8.delete();
    comp8.delete();
    clr8.delete();
  endtask

  function automatic logic [5:0] outs8();
    return {b8.in_ready, b8.busy, b8.frame_clr, b8.ser_valid, b8.ser_out, b8.ser_last};
  endfunction

  function automatic logic [5:0] outs2();
    return {b2.in_ready, b2.busy, b2.frame_clr, b2.ser_valid, b2.ser_out, b2.ser_last};
  endfunction

  int w0, w1, w2;
  int nw, nc;

  initial begin
    // Word 8'h06 then 8'h00, one row per cycle.
    add8(1, 8'h06, 6'b100000);
    add8(0, 8'h00, 6'b010000);
    add8(0, 8'h00, 6'b111000);
    add8(0, 8'h00, 6'b110100);
    add8(0, 8'h00, 6'b110110);
    add8(0, 8'h00, 6'b110110);
    add8(0, 8'h00, 6'b110100);
    add8(0, 8'h00, 6'b110100);
    add8(0, 8'h00, 6'b110100);
    add8(0, 8'h00, 6'b110100);
    add8(0, 8'h00, 6'b110101);
    add8(0, 8'h00, 6'b100000);
    add8(1, 8'h00, 6'b100000);
    add8(0, 8'h00, 6'b010000);
    add8(0, 8'h00, 6'b111000);
    for (int i = 0; i < 7; i++) add8(0, 8'h00, 6'b110100);
    add8(0, 8'h00, 6'b110101);
    add8(0, 8'h00, 6'b100000);

    // WIDTH=2: 2'b10 then 2'b01 back-to-back.
    add2(1, 8'h02, 6'b100000);
    add2(1, 8'h01, 6'b010000);
    add2(1, 8'h01, 6'b111000);
    add2(0, 8'h00, 6'b010100);
    add2(0, 8'h00, 6'b010111);
    add2(0, 8'h00, 6'b111000);
    add2(0, 8'h00, 6'b110110);
    add2(0, 8'h00, 6'b110101);
    add2(0, 8'h00, 6'b100000);
    add2(0, 8'h00, 6'b100000);

    b8.in_valid = 1'b0;
    b8.in_data  = '0;
    b2.in_valid = 1'b0;
    b2.in_data  = '0;
    reset = 1'b1;
    tick();
    tick();
    check("reset outs8", outs8(), 6'b100000);
    check("reset outs2", outs2(), 6'b100000);
    reset = 1'b0;
    tick();

    foreach (t8[i]) begin
      b8.in_valid = t8[i].v;
      b8.in_data  = t8[i].d;
      check($sformatf("w8 row %0d", i), outs8(), t8[i].exp);
      tick();
    end
    b8.in_valid = 1'b0;
    repeat (4) tick();
    check_words("single words", words8, '{8'h06, 8'h00});
    check_words("single comp", comp8, '{8'hFA, 8'h00});

    foreach (t2[i]) begin
      b2.in_valid = t2[i].v;
      b2.in_data  = t2[i].d[1:0];
      check($sformatf("w2 row %0d", i), outs2(), t2[i].exp);
      tick();
    end
    b2.in_valid = 1'b0;

    // Back-to-back with in_valid held high.
    clear_mon();
    send8(8'h01, w0);
    send8(8'h80, w1);
    send8(8'hFF, w2);
    b8.in_valid = 1'b0;
    check("b2b hold-full stall", w1, 1);
    repeat (30) tick();
    check_words("b2b words", words8, '{8'h01, 8'h80, 8'hFF});
    check_words("b2b comp", comp8, '{8'hFF, 8'h80, 8'h01});
    check("b2b clr count", clr8.size(), 3);
    for (int i = 0; i < 2; i++)
      check($sformatf("b2b period %0d", i),
            (clr8.size() == 3) ? clr8[i+1] - clr8[i] : -1, 9);
    check("b2b idle", outs8(), 6'b100000);

    // Backpressure: third word held off until the hold register drains.
    clear_mon();
    send8(8'h55, w0);
    b8.in_valid = 1'b0;
    repeat (3) tick();
    send8(8'hAA, w1);
    send8(8'h33, w2);
    b8.in_valid = 1'b0;
    check("bp AA wait", w1, 0);
    check("bp 33 wait", w2, 6);
    repeat (30) tick();
    check_words("bp words", words8, '{8'h55, 8'hAA, 8'h33});

    // Reset at bit 3 of 8'h0F with 8'h3C buffered.
    clear_mon();
    send8(8'h0F, w0);
    send8(8'h3C, w1);
    b8.in_valid = 1'b0;
    repeat (3) tick();
    check("pre-reset bit3", outs8(), 6'b010110);
    nw = words8.size();
    nc = clr8.size();
    reset = 1'b1;
    #1;
    check("async reset outs", outs8(), 6'b100000);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("post-reset words", words8.size(), nw);
    check("post-reset clr", clr8.size(), nc);
    check("post-reset idle", outs8(), 6'b100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
